tuart_rx: RTL
=============

// Module: tuart_rx
//
// PURPOSE
//   UART receiver that pairs with tuart_tx. It deserialises 8N1 frames from
//   rx_i and assembles them into commands: one opcode word, then CMD_WORDS
//   argument words when the opcode MSB is set. It strobes each complete
//   command to the core and decodes XON/XOFF opcodes into the xstb/xon/xoff
//   flow-control inputs of tuart_tx.
//
// PARAMETERS
//   WORD_BITS       8   data bits per UART frame; also the opcode width
//   CMD_WORDS       4   argument words that follow a long opcode (MSB=1)
//   CLK_PER_SAMPLE  5   clk_i cycles per UART bit; must be >= 3
//
// PORTS
//   clk_i     in   1                      system clock
//   rst_in    in   1                      reset, asynchronous, active-low
//   rx_i      in   1                      serial input, idle high, async to clk_i
//   opcode_o  out  WORD_BITS              opcode of the last command
//   cmd_o     out  WORD_BITS*CMD_WORDS    arguments; first received word in bits [WORD_BITS-1:0]
//   stb_o     out  1                      1-cycle pulse: opcode_o/cmd_o valid
//   xstb_o    out  1                      1-cycle pulse: flow-control opcode received
//   xon_o     out  1                      valid with xstb_o: opcode was XON (0x11)
//   xoff_o    out  1                      valid with xstb_o: opcode was XOFF (0x13)
//   err_o     out  1                      1-cycle pulse: framing error (stop bit = 0)
//
// BEHAVIOUR
//   - Reset: all outputs 0, FSM = IDLE, word counter 0, synchroniser flops 1.
//   - rx_i passes through a 2-flop synchroniser; all logic uses the sync'd bit.
//   - Bit FSM:
//       IDLE  -> START on sync'd rx = 0; load bit timer with CLK_PER_SAMPLE/2.
//       START -> at timer expiry sample: 0 -> DATA (timer = CLK_PER_SAMPLE);
//                1 -> IDLE (glitch, nothing reported).
//       DATA  -> sample every CLK_PER_SAMPLE cycles, LSB first, WORD_BITS bits,
//                then -> STOP.
//       STOP  -> sample after CLK_PER_SAMPLE cycles. 1: word accepted -> IDLE.
//                0: err_o pulse, word dropped, word counter cleared -> BREAK.
//       BREAK -> IDLE once sync'd rx = 1.
//   - Command assembly on an accepted word:
//       wcnt = 0, word = 0x11 or 0x13: xstb_o pulse; xon_o / xoff_o set.
//                 No stb_o. wcnt stays 0.
//       wcnt = 0, MSB = 0: opcode_o <= word, cmd_o <= 0, stb_o pulse.
//       wcnt = 0, MSB = 1: opcode_o <= word, wcnt <= 1. No stb_o yet.
//       wcnt = k >= 1: cmd_o[(k-1)*WORD_BITS +: WORD_BITS] <= word.
//                 When k = CMD_WORDS: stb_o pulse and wcnt <= 0; else wcnt++.
//   - Latency:
//       stb_o / xstb_o assert on the cycle after the clock edge that samples
//       a good stop bit.
//       opcode_o / cmd_o / xon_o / xoff_o are registered and stay stable
//       until the next update.
//   - Flow-control bytes in argument position are treated as plain data.
//   - There is no inter-byte timeout: a long command waits indefinitely.
//   - Asynchronous reset mid-frame or mid-command discards all partial state.
//   - stb_o, xstb_o and err_o are mutually exclusive and never wider than 1 cycle.
//
// TESTING  (CLK_PER_SAMPLE = 5, WORD_BITS = 8, CMD_WORDS = 4)
//   - Send frame 0x00 -> exactly one stb_o, opcode_o = 0x00, cmd_o = 0.
//   - Send 0x80, 0x11, 0x22, 0x33, 0x44 -> one stb_o after the 5th stop bit,
//     opcode_o = 0x80, cmd_o = 0x44332211; no xstb_o.
//   - Send 0x13, then 0x11 -> xstb_o with xoff_o = 1, xon_o = 0, then xstb_o
//     with xon_o = 1, xoff_o = 0; stb_o never asserts.
//   - Drive rx_i low for 2 cycles, then high -> no stb_o, xstb_o or err_o;
//     a following 0x05 frame is received correctly.
//   - Send 0xC0, 0xAA, then a frame with stop bit = 0 -> err_o pulse;
//     a following 0x01 is received as a new short command (stb_o, opcode_o = 0x01).
//   - Assert rst_in low during the 3rd word of a long command -> all outputs 0;
//     after release, 0x02 yields stb_o with opcode_o = 0x02.

Source files
------------

// File: rtl/tuart_rx.sv
// 8N1 UART receiver that assembles opcode/argument commands and decodes
// XON/XOFF opcodes into strobes for the companion transmitter.
module tuart_rx #(
   parameter int WORD_BITS      = 8,
   parameter int CMD_WORDS      = 4,
   parameter int CLK_PER_SAMPLE = 5
) (
   input  logic                           clk_i,
   input  logic                           rst_in,
   input  logic                           rx_i,
   output logic [WORD_BITS-1:0]           opcode_o,
   output logic [WORD_BITS*CMD_WORDS-1:0] cmd_o,
   output logic                           stb_o,
   output logic                           xstb_o,
   output logic                           xon_o,
   output logic                           xoff_o,
   output logic                           err_o
);

   // stb_o, xstb_o and err_o are one-cycle strobes with no back-pressure; the
   // core must take opcode_o/cmd_o (or xon_o/xoff_o) on the strobe cycle, and
   // those values then hold until the next command updates them.
   localparam int TMR_W  = $clog2(CLK_PER_SAMPLE + 1);
   localparam int BIT_W  = $clog2(WORD_BITS + 1);
   localparam int WCNT_W = $clog2(CMD_WORDS + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   localparam logic [TMR_W-1:0]     TMR_FULL = TMR_W'(CLK_PER_SAMPLE);
   localparam logic [TMR_W-1:0]     TMR_HALF = TMR_W'(CLK_PER_SAMPLE / 2);
   localparam logic [TMR_W-1:0]     TMR_ONE  = TMR_W'(1);
   localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(WORD_BITS - 1);
   localparam logic [WCNT_W-1:0]    WCNT_END = WCNT_W'(CMD_WORDS);
   localparam logic [WORD_BITS-1:0] XON_CODE  = WORD_BITS'(8'h11);
   localparam logic [WORD_BITS-1:0] XOFF_CODE = WORD_BITS'(8'h13);

   logic                           rx_meta_q, rx_sync_q;
   logic [2:0]                     state_q, state_d;
   logic [TMR_W-1:0]               tmr_q, tmr_d;
   logic [BIT_W-1:0]               bit_cnt_q, bit_cnt_d;
   logic [WORD_BITS-1:0]           sh_q, sh_d;
   logic [WCNT_W-1:0]              wcnt_q, wcnt_d;
   logic [WORD_BITS-1:0]           opcode_q, opcode_d;
   logic [WORD_BITS*CMD_WORDS-1:0] cmd_q, cmd_d;
   logic                           stb_q, stb_d, xstb_q, xstb_d, err_q, err_d;
   logic                           xon_q, xon_d, xoff_q, xoff_d;
   logic                           word_ok;

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      wcnt_d    = wcnt_q;
      opcode_d  = opcode_q;
      cmd_d     = cmd_q;
      xon_d     = xon_q;
      xoff_d    = xoff_q;
      stb_d     = 1'b0;
      xstb_d    = 1'b0;
      err_d     = 1'b0;
      word_ok   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rx_sync_q) begin
               state_d = S_START;
               tmr_d   = TMR_HALF;
            end
         end
         S_START: begin
            if (tmr_q == TMR_ONE) begin
               if (!rx_sync_q) begin
                  state_d   = S_DATA;
                  tmr_d     = TMR_FULL;
                  bit_cnt_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_DATA: begin
            if (tmr_q == TMR_ONE) begin
               sh_d  = {rx_sync_q, sh_q[WORD_BITS-1:1]};
               tmr_d = TMR_FULL;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_STOP: begin
            if (tmr_q == TMR_ONE) begin
               if (rx_sync_q) begin
                  state_d = S_IDLE;
                  word_ok = 1'b1;
               end else begin
                  state_d = S_BREAK;
                  err_d   = 1'b1;
                  wcnt_d  = '0;
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_BREAK: begin
            if (rx_sync_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Flow-control codes are only decoded in opcode position.
      if (word_ok) begin
         if (wcnt_q == '0) begin
            if (sh_q == XON_CODE || sh_q == XOFF_CODE) begin
               xstb_d = 1'b1;
               xon_d  = (sh_q == XON_CODE);
               xoff_d = (sh_q == XOFF_CODE);
            end else if (!sh_q[WORD_BITS-1]) begin
               opcode_d = sh_q;
               cmd_d    = '0;
               stb_d    = 1'b1;
            end else begin
               opcode_d = sh_q;
               wcnt_d   = WCNT_W'(1);
            end
         end else begin
            for (int k = 0; k < CMD_WORDS; k++) begin
               if (wcnt_q == WCNT_W'(k + 1)) begin
                  cmd_d[k*WORD_BITS +: WORD_BITS] = sh_q;
               end
            end
            if (wcnt_q == WCNT_END) begin
               stb_d  = 1'b1;
               wcnt_d = '0;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= S_IDLE;
         tmr_q     <= '0;
         bit_cnt_q <= '0;
         sh_q      <= '0;
         wcnt_q    <= '0;
         opcode_q  <= '0;
         cmd_q     <= '0;
         xon_q     <= 1'b0;
         xoff_q    <= 1'b0;
         stb_q     <= 1'b0;
         xstb_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         bit_cnt_q <= bit_cnt_d;
         sh_q      <= sh_d;
         wcnt_q    <= wcnt_d;
         opcode_q  <= opcode_d;
         cmd_q     <= cmd_d;
         xon_q     <= xon_d;
         xoff_q    <= xoff_d;
         stb_q     <= stb_d;
         xstb_q    <= xstb_d;
         err_q     <= err_d;
      end
   end

   assign opcode_o = opcode_q;
   assign cmd_o    = cmd_q;
   assign stb_o    = stb_q;
   assign xstb_o   = xstb_q;
   assign xon_o    = xon_q;
   assign xoff_o   = xoff_q;
   assign err_o    = err_q;

endmodule
